// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: three requester ports (render, CPU, DMA) plus the
// single-port VRAM pins. The slave modport is the arbiter's view, the master
// modport is the view of the requesters and the VRAM itself.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // render fetch (reads only)
  logic              rnd_req;
  logic [ADDR_W-1:0] rnd_addr;
  logic              rnd_gnt;
  logic              rnd_rvalid;
  logic [DATA_W-1:0] rnd_rdata;
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // VRAM-VRAM / SATB DMA
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  // VRAM pins
  logic [ADDR_W-1:0] MA;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] MD_in;
  logic [DATA_W-1:0] MD_out;

  modport slave (
    input  rnd_req, rnd_addr,
    output rnd_gnt, rnd_rvalid, rnd_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output MA, re, we, MD_in,
    input  MD_out
  );

  modport master (
    output rnd_req, rnd_addr,
    input  rnd_gnt, rnd_rvalid, rnd_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  MA, re, we, MD_in,
    output MD_out
  );
endinterface

// File: rtl/vram_arbiter.sv
// HuC6270 VRAM arbiter. One access per clock: render has fixed priority,
// CPU and DMA alternate round-robin, and a starvation counter forces one
// CPU/DMA slot after STARVE_LIMIT consecutive render wins. VRAM read data
// arrives one cycle after re and is steered back using an owner tag.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clock,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RND  = 2'd1,
    TAG_CPU  = 2'd2,
    TAG_DMA  = 2'd3
  } tag_t;

  typedef enum logic {
    RR_CPU = 1'b0,
    RR_DMA = 1'b1
  } rr_t;

  localparam int              CNT_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam bit              FORCE_EN = (STARVE_LIMIT != 0);

  tag_t              tag_r;
  rr_t               rr_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [ADDR_W-1:0] ma_r;
  logic [DATA_W-1:0] md_r;

  logic              force_s;
  logic              rnd_gnt_s;
  logic              cpu_gnt_s;
  logic              dma_gnt_s;
  logic              any_gnt_s;
  logic              we_sel_s;
  logic [ADDR_W-1:0] addr_sel_s;
  logic [DATA_W-1:0] wdata_sel_s;
  tag_t              tag_next_s;

  // Pick this cycle's single winner; reset blocks every grant.
  always_comb begin
    force_s   = 1'b0;
    rnd_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    if (FORCE_EN && (wait_cnt_r == CNT_MAX) && (bus.cpu_req || bus.dma_req)) begin
      force_s = 1'b1;
    end else begin
      force_s = 1'b0;
    end
    if (reset) begin
      rnd_gnt_s = 1'b0;
    end else if (bus.rnd_req && !force_s) begin
      rnd_gnt_s = 1'b1;
    end else if (bus.cpu_req && bus.dma_req) begin
      cpu_gnt_s = (rr_r == RR_CPU);
      dma_gnt_s = (rr_r == RR_DMA);
    end else if (bus.cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (bus.dma_req) begin
      dma_gnt_s = 1'b1;
    end else begin
      rnd_gnt_s = 1'b0;
    end
  end

  // Route the winner's access to the VRAM side and decide the read owner.
  always_comb begin
    any_gnt_s   = rnd_gnt_s | cpu_gnt_s | dma_gnt_s;
    we_sel_s    = 1'b0;
    addr_sel_s  = ma_r;
    wdata_sel_s = md_r;
    tag_next_s  = TAG_NONE;
    if (rnd_gnt_s) begin
      addr_sel_s = bus.rnd_addr;
      tag_next_s = TAG_RND;
    end else if (cpu_gnt_s) begin
      we_sel_s    = bus.cpu_we;
      addr_sel_s  = bus.cpu_addr;
      wdata_sel_s = bus.cpu_wdata;
      tag_next_s  = bus.cpu_we ? TAG_NONE : TAG_CPU;
    end else if (dma_gnt_s) begin
      we_sel_s    = bus.dma_we;
      addr_sel_s  = bus.dma_addr;
      wdata_sel_s = bus.dma_wdata;
      tag_next_s  = bus.dma_we ? TAG_NONE : TAG_DMA;
    end else begin
      tag_next_s = TAG_NONE;
    end
  end

  // Drive VRAM pins: live access when granted, otherwise hold MA/MD_in.
  always_comb begin
    bus.re = any_gnt_s & ~we_sel_s;
    bus.we = any_gnt_s & we_sel_s;
    if (reset) begin
      bus.MA    = '0;
      bus.MD_in = '0;
    end else if (any_gnt_s) begin
      bus.MA    = addr_sel_s;
      bus.MD_in = wdata_sel_s;
    end else begin
      bus.MA    = ma_r;
      bus.MD_in = md_r;
    end
  end

  // Return read data to the owner recorded in the previous cycle.
  always_comb begin
    bus.rnd_gnt    = rnd_gnt_s;
    bus.cpu_gnt    = cpu_gnt_s;
    bus.dma_gnt    = dma_gnt_s;
    bus.rnd_rvalid = 1'b0;
    bus.cpu_rvalid = 1'b0;
    bus.dma_rvalid = 1'b0;
    if (!reset) begin
      case (tag_r)
        TAG_RND: bus.rnd_rvalid = 1'b1;
        TAG_CPU: bus.cpu_rvalid = 1'b1;
        TAG_DMA: bus.dma_rvalid = 1'b1;
        default: bus.rnd_rvalid = 1'b0;
      endcase
    end else begin
      bus.rnd_rvalid = 1'b0;
    end
    bus.rnd_rdata = bus.rnd_rvalid ? bus.MD_out : '0;
    bus.cpu_rdata = bus.cpu_rvalid ? bus.MD_out : '0;
    bus.dma_rdata = bus.dma_rvalid ? bus.MD_out : '0;
  end

  // Hold registers for the VRAM pins and the read-owner tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ma_r  <= '0;
      md_r  <= '0;
      tag_r <= TAG_NONE;
    end else begin
      if (any_gnt_s) begin
        ma_r <= addr_sel_s;
        md_r <= wdata_sel_s;
      end else begin
        ma_r <= ma_r;
        md_r <= md_r;
      end
      tag_r <= tag_next_s;
    end
  end

  // Round-robin pointer and starvation counter for the CPU/DMA pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_r       <= RR_CPU;
      wait_cnt_r <= '0;
    end else begin
      if (cpu_gnt_s) begin
        rr_r <= RR_DMA;
      end else if (dma_gnt_s) begin
        rr_r <= RR_CPU;
      end else begin
        rr_r <= rr_r;
      end
      if (cpu_gnt_s || dma_gnt_s) begin
        wait_cnt_r <= '0;
      end else if (!(bus.cpu_req || bus.dma_req)) begin
        wait_cnt_r <= '0;
      end else if (rnd_gnt_s && (wait_cnt_r != CNT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural VRAM, a read-return scoreboard and
// one task per scenario. STARVE_LIMIT is 4 so the forced-slot pattern is short.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int OWN_RND = 1;
  localparam int OWN_CPU = 2;
  localparam int OWN_DMA = 3;

  logic clock;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  int          exp_who[$];
  logic [15:0] exp_data[$];

  logic        pre_en;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:65535];

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port VRAM with registered read data, plus a bench preload port.
  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.we) mem[bus.MA] <= bus.MD_in;
    if (bus.re) bus.MD_out <= mem[bus.MA];
  end

  // Scoreboard: every rvalid must match the oldest expected read return.
  always @(negedge clock) begin
    int nv;
    int who;
    int w;
    logic [15:0] d;
    logic [15:0] data;
    if (!reset) begin
      nv = int'(bus.rnd_rvalid) + int'(bus.cpu_rvalid) + int'(bus.dma_rvalid);
      if (nv > 1) begin
        vectors++;
        miscompares++;
        $display("FAIL rvalid_onehot: got %0d rvalids required 1", nv);
      end else if (nv == 1) begin
        vectors++;
        who  = bus.rnd_rvalid ? OWN_RND : (bus.cpu_rvalid ? OWN_CPU : OWN_DMA);
        data = bus.rnd_rvalid ? bus.rnd_rdata : (bus.cpu_rvalid ? bus.cpu_rdata : bus.dma_rdata);
        if (exp_who.size() == 0) begin
          miscompares++;
          $display("FAIL rdata_unexpected: got owner %0d data %04h required no return", who, data);
        end else begin
          w = exp_who.pop_front();
          d = exp_data.pop_front();
          if (who !== w || data !== d) begin
            miscompares++;
            $display("FAIL rdata: got owner %0d data %04h required owner %0d data %04h", who, data, w, d);
          end
        end
      end
    end
  end

  function automatic int gcode();
    int n;
    n = int'(bus.rnd_gnt) + int'(bus.cpu_gnt) + int'(bus.dma_gnt);
    if (n > 1) return 4;
    if (bus.rnd_gnt) return OWN_RND;
    if (bus.cpu_gnt) return OWN_CPU;
    if (bus.dma_gnt) return OWN_DMA;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    bus.rnd_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.dma_we  = 1'b0;
  endtask

  task automatic expect_read(input int who, input logic [15:0] data);
    exp_who.push_back(who);
    exp_data.push_back(data);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rnd_req = 1'b1; bus.rnd_addr = 16'h0010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0011; bus.cpu_wdata = 16'h1234;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0012; bus.dma_wdata = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if ({bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.rnd_rvalid, bus.cpu_rvalid, bus.dma_rvalid,
           bus.re, bus.we, bus.MA, bus.MD_in} !== 40'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got gnt %b%b%b rv %b%b%b re %b we %b MA %04h MD_in %04h required all 0",
                 bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.rnd_rvalid, bus.cpu_rvalid, bus.dma_rvalid,
                 bus.re, bus.we, bus.MA, bus.MD_in);
      end
      tick();
    end
    reset = 1'b0;
    expect_read(OWN_RND, 16'h1111);
    @(negedge clock);
    vectors++;
    if ({bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.re, bus.MA} !== {4'b1001, 16'h0010}) begin
      miscompares++;
      $display("FAIL first_grant: got gnt %b%b%b re %b MA %04h required gnt 100 re 1 MA 0010",
               bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.re, bus.MA);
    end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_cpu_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    expect_read(OWN_CPU, 16'hBEEF);
    @(negedge clock);
    vectors++;
    if ({bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.re, bus.we, bus.MA} !== {5'b01010, 16'h1234}) begin
      miscompares++;
      $display("FAIL cpu_read_grant: got gnt %b%b%b re %b we %b MA %04h required gnt 010 re 1 we 0 MA 1234",
               bus.rnd_gnt, bus.cpu_gnt, bus.dma_gnt, bus.re, bus.we, bus.MA);
    end
    tick();
    idle_all();
    @(negedge clock);
    vectors++;
    if ({bus.cpu_rvalid, bus.cpu_rdata, bus.re, bus.we, bus.MA} !== {1'b1, 16'hBEEF, 2'b00, 16'h1234}) begin
      miscompares++;
      $display("FAIL cpu_read_return: got rvalid %b rdata %04h re %b we %b MA %04h required 1 BEEF 0 0 1234",
               bus.cpu_rvalid, bus.cpu_rdata, bus.re, bus.we, bus.MA);
    end
    tick();
  endtask

  task automatic test_priority_rr();
    int ord [5] = '{OWN_RND, OWN_CPU, OWN_DMA, OWN_CPU, OWN_DMA};
    logic [15:0] dat [4] = '{16'h0000, 16'hA001, 16'hC002, 16'hD003};
    int g;
    apply_reset();
    bus.rnd_req = 1'b1; bus.rnd_addr = 16'h0100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0101;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0102;
    for (int i = 0; i < 5; i++) begin
      expect_read(ord[i], dat[ord[i]]);
      @(negedge clock);
      vectors++;
      g = gcode();
      if (g !== ord[i]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got grant %0d required %0d", i, g, ord[i]);
      end
      tick();
      if (i == 0) bus.rnd_req = 1'b0;
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_starvation();
    int e;
    int g;
    apply_reset();
    bus.rnd_req = 1'b1; bus.rnd_addr = 16'h0300;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 16'h5A5A;
    for (int i = 0; i < 15; i++) begin
      e = ((i % 5) == 4) ? OWN_CPU : OWN_RND;
      if (e == OWN_RND) expect_read(OWN_RND, 16'h3333);
      @(negedge clock);
      vectors++;
      g = gcode();
      if (g !== e) begin
        miscompares++;
        $display("FAIL starve[%0d]: got grant %0d required %0d", i, g, e);
      end
      if (e == OWN_CPU) begin
        vectors++;
        if ({bus.we, bus.re, bus.MA, bus.MD_in} !== {2'b10, 16'h0200, 16'h5A5A}) begin
          miscompares++;
          $display("FAIL starve_write[%0d]: got we %b re %b MA %04h MD_in %04h required 1 0 0200 5A5A",
                   i, bus.we, bus.re, bus.MA, bus.MD_in);
        end
      end
      tick();
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_write_then_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0042; bus.cpu_wdata = 16'hA5A5;
    @(negedge clock);
    vectors++;
    if ({bus.cpu_gnt, bus.we, bus.re, bus.MA, bus.MD_in} !== {3'b110, 16'h0042, 16'hA5A5}) begin
      miscompares++;
      $display("FAIL raw_write: got gnt %b we %b re %b MA %04h MD_in %04h required 1 1 0 0042 A5A5",
               bus.cpu_gnt, bus.we, bus.re, bus.MA, bus.MD_in);
    end
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.rnd_req = 1'b1; bus.rnd_addr = 16'h0042;
    expect_read(OWN_RND, 16'hA5A5);
    @(negedge clock);
    vectors++;
    if ({bus.rnd_gnt, bus.re, bus.we} !== 3'b110) begin
      miscompares++;
      $display("FAIL raw_read_grant: got gnt %b re %b we %b required 1 1 0", bus.rnd_gnt, bus.re, bus.we);
    end
    tick();
    idle_all();
    @(negedge clock);
    vectors++;
    if ({bus.rnd_rvalid, bus.rnd_rdata} !== {1'b1, 16'hA5A5}) begin
      miscompares++;
      $display("FAIL raw_return: got rvalid %b rdata %04h required 1 A5A5", bus.rnd_rvalid, bus.rnd_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int g;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0400;
    @(negedge clock);
    vectors++;
    if (bus.dma_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL lone_dma_grant: got %b required 1", bus.dma_gnt);
    end
    tick();
    idle_all();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({bus.dma_rvalid, bus.re, bus.we, bus.MA} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_kills_read: got rvalid %b re %b we %b MA %04h required 0 0 0 0000",
               bus.dma_rvalid, bus.re, bus.we, bus.MA);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({bus.rnd_rvalid, bus.cpu_rvalid, bus.dma_rvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL tag_cleared: got rvalid %b%b%b required 000", bus.rnd_rvalid, bus.cpu_rvalid, bus.dma_rvalid);
    end
    tick();
    // CPU grant points rr at DMA; reset must return it to CPU.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0401; bus.cpu_wdata = 16'h0001;
    tick();
    idle_all();
    apply_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0402;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0403;
    expect_read(OWN_CPU, 16'h4402);
    @(negedge clock);
    vectors++;
    g = gcode();
    if (g !== OWN_CPU) begin
      miscompares++;
      $display("FAIL rr_after_reset: got grant %0d required %0d", g, OWN_CPU);
    end
    tick();
    bus.cpu_req = 1'b0;
    expect_read(OWN_DMA, 16'h4403);
    @(negedge clock);
    vectors++;
    g = gcode();
    if (g !== OWN_DMA) begin
      miscompares++;
      $display("FAIL dma_after_cpu: got grant %0d required %0d", g, OWN_DMA);
    end
    tick();
    idle_all();
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    pre_en = 1'b0;
    pre_addr = 16'h0000;
    pre_data = 16'h0000;
    idle_all();
    bus.rnd_addr = 16'h0000;
    bus.cpu_addr = 16'h0000;
    bus.dma_addr = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    bus.dma_wdata = 16'h0000;
    preload(16'h0010, 16'h1111);
    preload(16'h1234, 16'hBEEF);
    preload(16'h0100, 16'hA001);
    preload(16'h0101, 16'hC002);
    preload(16'h0102, 16'hD003);
    preload(16'h0300, 16'h3333);
    preload(16'h0042, 16'h0000);
    preload(16'h0400, 16'h4444);
    preload(16'h0402, 16'h4402);
    preload(16'h0403, 16'h4403);

    test_reset();
    test_cpu_read();
    test_priority_rr();
    test_starvation();
    test_write_then_read();
    test_reset_mid_read();

    tick();
    vectors++;
    if (exp_who.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending returns required 0", exp_who.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
